// File: rtl/bbox_pkg.sv
// Shared definitions for the serial bounding-box engine and the rasteriser setup
// stage that consumes its four result lanes.
package bbox_pkg;

  localparam int BBOX_COORD_W = 9;
  localparam int BBOX_NVERT   = 3;

  typedef enum logic {
    AXIS_X = 1'b0,
    AXIS_Y = 1'b1
  } axis_t;

  // Lane order of the result bus; the rasteriser setup indexes results the same way.
  localparam int OUT_XMIN  = 0;
  localparam int OUT_XMAX  = 1;
  localparam int OUT_YMIN  = 2;
  localparam int OUT_YMAX  = 3;
  localparam int OUT_LANES = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bbox_piso.sv
// Parallel-load, shift-left serialiser: emits W bits MSB first after a load,
// with valid high for exactly those W cycles and zeros shifted in behind.
module bbox_piso #(
  parameter int W = 9
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] pdata,
  output logic         sout,
  output logic         valid
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  sreg;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= pdata;
      cnt  <= CW'(W);
    end else if (cnt != '0) begin
      sreg <= {sreg[W-2:0], 1'b0};
      cnt  <= cnt - 1'b1;
    end
  end

  assign sout  = sreg[W-1];
  assign valid = (cnt != '0);

endmodule

// File: rtl/bbox_serial_n.sv
// Serial bounding-box engine: running min/max over a bit-serial vertex stream,
// results serialised on four parallel lanes while the next frame is received.
module bbox_serial_n
  import bbox_pkg::*;
#(
  parameter int COORD_W  = BBOX_COORD_W,
  parameter int NVERT    = BBOX_NVERT,
  parameter int CLAMP_EN = 0,
  parameter int XLIM     = (1 << COORD_W) - 1,
  parameter int YLIM     = (1 << COORD_W) - 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  input  logic EN,
  output logic XMINI,
  output logic XMAXI,
  output logic YMINI,
  output logic YMAXI,
  output logic OVALID,
  output logic DEGEN,
  output logic BUSY
);

  localparam int BW = cnt_w(COORD_W);
  localparam int VW = cnt_w(NVERT);
  localparam logic [COORD_W-1:0] XLIM_C = XLIM[COORD_W-1:0];
  localparam logic [COORD_W-1:0] YLIM_C = YLIM[COORD_W-1:0];

  logic [COORD_W-2:0] shift_reg;
  logic [BW-1:0]      bit_cnt;
  logic [VW-1:0]      vert_cnt;
  axis_t              axis;
  logic [COORD_W-1:0] run_min, run_max;
  logic [COORD_W-1:0] xmin_h, xmax_h;
  logic               degen_r;

  logic [COORD_W-1:0] coord, lim, cval, new_min, new_max;
  logic               first_vert, last_bit, last_vert, frame_end;

  always_comb begin
    coord      = {shift_reg, D};
    lim        = (axis == AXIS_Y) ? YLIM_C : XLIM_C;
    cval       = (CLAMP_EN != 0 && coord > lim) ? lim : coord;
    first_vert = (vert_cnt == '0);
    new_min    = (first_vert || cval < run_min) ? cval : run_min;
    new_max    = (first_vert || cval > run_max) ? cval : run_max;
    last_bit   = EN && (bit_cnt == BW'(COORD_W - 1));
    last_vert  = (vert_cnt == VW'(NVERT - 1));
    frame_end  = last_bit && last_vert && (axis == AXIS_Y);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      vert_cnt  <= '0;
      axis      <= AXIS_X;
      run_min   <= '0;
      run_max   <= '0;
      xmin_h    <= '0;
      xmax_h    <= '0;
      degen_r   <= 1'b0;
    end else if (EN) begin
      shift_reg <= coord[COORD_W-2:0];
      if (last_bit) begin
        bit_cnt <= '0;
        run_min <= new_min;
        run_max <= new_max;
        if (last_vert) begin
          vert_cnt <= '0;
          if (axis == AXIS_X) begin
            // Park the X extremes so the running comparators can serve Y.
            xmin_h <= new_min;
            xmax_h <= new_max;
            axis   <= AXIS_Y;
          end else begin
            axis    <= AXIS_X;
            degen_r <= (xmin_h == xmax_h) || (new_min == new_max);
          end
        end else begin
          vert_cnt <= vert_cnt + 1'b1;
        end
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  logic [OUT_LANES-1:0][COORD_W-1:0] res;
  logic [OUT_LANES-1:0]              ser, vld;

  always_comb begin
    res           = '0;
    res[OUT_XMIN] = xmin_h;
    res[OUT_XMAX] = xmax_h;
    res[OUT_YMIN] = new_min;
    res[OUT_YMAX] = new_max;
  end

  for (genvar g = 0; g < OUT_LANES; g++) begin : g_lane
    bbox_piso #(.W(COORD_W)) u_piso (
      .CLK   (CLK),
      .RST   (RST),
      .load  (frame_end),
      .pdata (res[g]),
      .sout  (ser[g]),
      .valid (vld[g])
    );
  end

  assign XMINI  = ser[OUT_XMIN];
  assign XMAXI  = ser[OUT_XMAX];
  assign YMINI  = ser[OUT_YMIN];
  assign YMAXI  = ser[OUT_YMAX];
  assign OVALID = vld[OUT_XMIN];
  // All lanes load together, so their valids coincide with OVALID.
  assign DEGEN  = degen_r & (&vld);
  assign BUSY   = (bit_cnt != '0) || (vert_cnt != '0) || (axis != AXIS_X);

endmodule

// File: tb/tb_bbox_serial_n.sv
// Directed bench for bbox_serial_n: default, clamping and wide/4-vertex instances.
module tb_bbox_serial_n;

  logic       CLK;
  logic       RST;
  logic [2:0] d_v, en_v;
  logic [2:0] xmin_v, xmax_v, ymin_v, ymax_v, ov_v, dg_v, busy_v;

  int vectors;
  int miscompares;

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  bbox_serial_n u_def (
    .CLK(CLK), .RST(RST), .D(d_v[0]), .EN(en_v[0]),
    .XMINI(xmin_v[0]), .XMAXI(xmax_v[0]), .YMINI(ymin_v[0]), .YMAXI(ymax_v[0]),
    .OVALID(ov_v[0]), .DEGEN(dg_v[0]), .BUSY(busy_v[0])
  );

  bbox_serial_n #(.CLAMP_EN(1), .XLIM(319), .YLIM(239)) u_clp (
    .CLK(CLK), .RST(RST), .D(d_v[1]), .EN(en_v[1]),
    .XMINI(xmin_v[1]), .XMAXI(xmax_v[1]), .YMINI(ymin_v[1]), .YMAXI(ymax_v[1]),
    .OVALID(ov_v[1]), .DEGEN(dg_v[1]), .BUSY(busy_v[1])
  );

  bbox_serial_n #(.COORD_W(12), .NVERT(4)) u_w12 (
    .CLK(CLK), .RST(RST), .D(d_v[2]), .EN(en_v[2]),
    .XMINI(xmin_v[2]), .XMAXI(xmax_v[2]), .YMINI(ymin_v[2]), .YMAXI(ymax_v[2]),
    .OVALID(ov_v[2]), .DEGEN(dg_v[2]), .BUSY(busy_v[2])
  );

  // driver: sends up to max_bits of a frame; leaves EN high on the last bit
  task automatic drive_frame(input int sel, input int w, input int nv, input int c[8],
                             input int gap_every, input int max_bits);
    int total, n, idx;
    total = 2 * nv * w;
    n     = (max_bits > 0 && max_bits < total) ? max_bits : total;
    idx   = 0;
    for (int k = 0; k < 2 * nv; k++) begin
      for (int b = w - 1; b >= 0; b--) begin
        if (idx < n) begin
          @(negedge CLK);
          d_v[sel]  = c[k][b];
          en_v[sel] = 1'b1;
          if (idx == 1) begin
            vectors++;
            if (busy_v[sel] !== 1'b1) begin
              miscompares++;
              $display("FAIL busy_rise dut%0d: got %b want 1", sel, busy_v[sel]);
            end
          end
          if (gap_every > 0 && ((idx + 1) % gap_every) == 0 && (idx + 1) < n) begin
            for (int g = 0; g < 3; g++) begin
              @(negedge CLK);
              en_v[sel] = 1'b0;
              d_v[sel]  = ~d_v[sel];
              vectors++;
              if (busy_v[sel] !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_gap dut%0d bit %0d: got %b want 1", sel, idx, busy_v[sel]);
              end
            end
          end
          idx++;
        end
      end
    end
  endtask

  task automatic deassert(input int sel);
    @(negedge CLK);
    en_v[sel] = 1'b0;
    d_v[sel]  = 1'b0;
  endtask

  // scoreboard: call right after the last bit was driven
  task automatic capture(input int sel, input int w, input string tag,
                         input logic [11:0] e_xmin, input logic [11:0] e_xmax,
                         input logic [11:0] e_ymin, input logic [11:0] e_ymax,
                         input logic e_degen);
    logic [11:0] a0, a1, a2, a3;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    for (int i = 0; i < w; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        vectors++;
        if (busy_v[sel] !== 1'b0) begin
          miscompares++;
          $display("FAIL %s busy_fall: got %b want 0", tag, busy_v[sel]);
        end
      end
      vectors++;
      if (ov_v[sel] !== 1'b1) begin
        miscompares++;
        $display("FAIL %s ovalid cycle %0d: got %b want 1", tag, i, ov_v[sel]);
      end
      vectors++;
      if (dg_v[sel] !== e_degen) begin
        miscompares++;
        $display("FAIL %s degen cycle %0d: got %b want %b", tag, i, dg_v[sel], e_degen);
      end
      a0 = {a0[10:0], xmin_v[sel]};
      a1 = {a1[10:0], xmax_v[sel]};
      a2 = {a2[10:0], ymin_v[sel]};
      a3 = {a3[10:0], ymax_v[sel]};
    end
    vectors++;
    if (a0 !== e_xmin) begin
      miscompares++;
      $display("FAIL %s xmin: got %0d want %0d", tag, a0, e_xmin);
    end
    vectors++;
    if (a1 !== e_xmax) begin
      miscompares++;
      $display("FAIL %s xmax: got %0d want %0d", tag, a1, e_xmax);
    end
    vectors++;
    if (a2 !== e_ymin) begin
      miscompares++;
      $display("FAIL %s ymin: got %0d want %0d", tag, a2, e_ymin);
    end
    vectors++;
    if (a3 !== e_ymax) begin
      miscompares++;
      $display("FAIL %s ymax: got %0d want %0d", tag, a3, e_ymax);
    end
    @(negedge CLK);
    vectors++;
    if ({ov_v[sel], dg_v[sel], xmin_v[sel], xmax_v[sel], ymin_v[sel], ymax_v[sel]} !== 6'b0) begin
      miscompares++;
      $display("FAIL %s idle_after: got ov=%b dg=%b ser=%b%b%b%b want all 0", tag,
               ov_v[sel], dg_v[sel], xmin_v[sel], xmax_v[sel], ymin_v[sel], ymax_v[sel]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 3; s++) begin
      vectors++;
      if ({xmin_v[s], xmax_v[s], ymin_v[s], ymax_v[s], ov_v[s], dg_v[s], busy_v[s]} !== 7'b0) begin
        miscompares++;
        $display("FAIL %s dut%0d: got %b want 0000000", tag, s,
                 {xmin_v[s], xmax_v[s], ymin_v[s], ymax_v[s], ov_v[s], dg_v[s], busy_v[s]});
      end
    end
  endtask

  int fa[8] = '{10, 300, 5, 7, 7, 100, 0, 0};
  int fb[8] = '{1, 1, 1, 2, 9, 4, 0, 0};
  int fc[8] = '{400, 10, 20, 250, 0, 5, 0, 0};
  int fd[8] = '{0, 511, 0, 511, 511, 511, 0, 0};
  int fw[8] = '{4095, 0, 2048, 7, 3, 3000, 12, 99};

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
  endtask

  task automatic test_basic();
    drive_frame(0, 9, 3, fa, 0, 0);
    fork
      capture(0, 9, "basic", 12'd5, 12'd300, 12'd7, 12'd100, 1'b0);
      deassert(0);
    join
  endtask

  task automatic test_gaps();
    drive_frame(0, 9, 3, fa, 5, 0);
    fork
      capture(0, 9, "gaps", 12'd5, 12'd300, 12'd7, 12'd100, 1'b0);
      deassert(0);
    join
  endtask

  task automatic test_back_to_back();
    drive_frame(0, 9, 3, fa, 0, 0);
    fork
      capture(0, 9, "b2b_first", 12'd5, 12'd300, 12'd7, 12'd100, 1'b0);
      drive_frame(0, 9, 3, fb, 0, 0);
    join
    fork
      capture(0, 9, "b2b_second", 12'd1, 12'd1, 12'd2, 12'd9, 1'b1);
      deassert(0);
    join
  endtask

  task automatic test_clamp();
    drive_frame(1, 9, 3, fc, 0, 0);
    fork
      capture(1, 9, "clamp", 12'd10, 12'd319, 12'd0, 12'd239, 1'b0);
      deassert(1);
    join
  endtask

  task automatic test_reset_mid();
    // abort a shift in progress
    drive_frame(0, 9, 3, fa, 0, 0);
    deassert(0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_all_zero("rst_mid_output");
    // discard a partial frame; the EN bit alongside RST must be ignored
    drive_frame(0, 9, 3, fb, 0, 30);
    @(negedge CLK);
    RST       = 1'b1;
    d_v[0]    = 1'b1;
    en_v[0]   = 1'b1;
    @(negedge CLK);
    RST       = 1'b0;
    en_v[0]   = 1'b0;
    d_v[0]    = 1'b0;
    check_all_zero("rst_mid_frame");
    drive_frame(0, 9, 3, fd, 0, 0);
    fork
      capture(0, 9, "after_rst", 12'd0, 12'd511, 12'd511, 12'd511, 1'b1);
      deassert(0);
    join
  endtask

  task automatic test_wide();
    drive_frame(2, 12, 4, fw, 0, 0);
    fork
      capture(2, 12, "wide", 12'd0, 12'd4095, 12'd3, 12'd3000, 1'b0);
      deassert(2);
    join
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST         = 1'b1;
    d_v         = '0;
    en_v        = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_clamp();
    test_reset_mid();
    test_wide();
    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bbox_serial_n.md
# bbox_serial_n

Parametrised serial bounding-box engine: accepts one primitive of NVERT vertices as a bit-serial stream of COORD_W-bit coordinates and emits XMIN/XMAX/YMIN/YMAX as four parallel bit-serial streams. It computes the extremes on the fly with running comparators, so it needs no full-frame buffer. It tolerates gaps in EN, optionally clamps to screen limits, flags zero-area boxes, and accepts back-to-back frames while the previous result is still shifting out. It sits between the serial vertex source and the rasteriser setup stage.

## Interface
- COORD_W, 9: coordinate width in bits (≥2)
- NVERT, 3: vertices per primitive (≥1)
- CLAMP_EN, 0: 1 = clamp results to XLIM/YLIM
- XLIM, 2**COORD_W-1: inclusive maximum X when clamping
- YLIM, 2**COORD_W-1: inclusive maximum Y when clamping

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- D  in  1  serial coordinate data, MSB first
- EN  in  1  D is valid this cycle
- XMINI  out  1  serial XMIN, MSB first
- XMAXI  out  1  serial XMAX, MSB first
- YMINI  out  1  serial YMIN, MSB first
- YMAXI  out  1  serial YMAX, MSB first
- OVALID  out  1  high during each of the COORD_W output bit cycles
- DEGEN  out  1  high with OVALID when XMIN==XMAX or YMIN==YMAX
- BUSY  out  1  a frame is partially received (any input counter non-zero)

## Operation
- Frame order: x0..x(NVERT-1), then y0..y(NVERT-1); each coordinate COORD_W bits MSB first; a frame is 2·NVERT·COORD_W valid bits.
- Only cycles with EN=1 advance the input. With EN=0, all input state holds and gaps of any length are legal.
- Input counters: bit_cnt 0..COORD_W-1, vert_cnt 0..NVERT-1, axis X→Y. All wrap to 0/X after the last bit of the last Y.
- Coordinate completion occurs on an EN cycle with bit_cnt==COORD_W-1. The value is {shift_reg, D}.
  - vert_cnt==0: the value loads both the running min and the running max.
  - otherwise: min = smaller, max = larger. Ties keep the existing value; the result is identical either way.
- At the X→Y transition, the X min/max are held in dedicated registers and the running min/max are reused for Y.
- Clamp (CLAMP_EN=1): results above the limit are replaced by the limit, per axis, before load. Min and max are clamped independently.
- Frame end is the EN bit that completes the last Y. On that edge, the four results are parallel-loaded into output shifters and DEGEN is computed from the clamped values.
- Output: COORD_W cycles, MSB first, OVALID=1 throughout. Outputs are not gated by EN.
- Back-to-back frames: a new frame may begin on the cycle after frame end. Output shifting is independent of input. Because 2·NVERT·COORD_W > COORD_W, a reload never overlaps an active shift.
- Idle: serial outputs, OVALID and DEGEN are 0.

## Timing
- Reset values: XMINI, XMAXI, YMINI, YMAXI, OVALID, DEGEN, BUSY = 0. All counters = 0, axis = X, shifters = 0.
- Latency: if the last bit is sampled at edge k, the MSB of each result and OVALID=1 are visible after edge k. The LSB appears after edge k+COORD_W-1, and OVALID=0 after edge k+COORD_W.
- BUSY rises after the first accepted bit of a frame and falls after the frame-end edge.
- RST mid-frame or mid-output: the partial frame is discarded, any shift in progress is aborted, and all outputs are 0 after the RST edge. An EN bit in the same cycle as RST is ignored.
- Simultaneous frame end and a new frame's first bit cannot occur; they are distinct EN cycles by construction.

## Structure
- Shared package bbox_pkg holds:
  - default COORD_W and NVERT
  - axis encoding AXIS_X=0, AXIS_Y=1
  - output-order constants shared with the rasteriser setup
- One sub-module, bbox_piso: COORD_W-bit parallel-load / shift-left serialiser with load and valid. It is instantiated four times; OVALID comes from the XMIN instance.
- Running min/max comparators stay inline in the top module.

## Test plan
- Default params, after RST, frame x=(10,300,5), y=(7,7,100) with EN continuous → OVALID high 9 cycles starting 1 cycle after last bit; serial XMIN=5, XMAX=300, YMIN=7, YMAX=100; DEGEN=0.
- Same frame with EN dropped 3 cycles after every 5 bits → identical outputs; OVALID still starts 1 cycle after the last valid bit; BUSY stays 1 across gaps.
- Frame above, then immediately x=(1,1,1), y=(2,9,4) → first result undisturbed; second gives XMIN=XMAX=1, YMIN=2, YMAX=9, DEGEN=1.
- CLAMP_EN=1, XLIM=319, YLIM=239, frame x=(400,10,20), y=(250,0,5) → XMIN=10, XMAX=319, YMIN=0, YMAX=239.
- RST pulsed at input bit 30, then frame x=(0,511,0), y=(511,511,511) → all outputs 0 after RST; then XMIN=0, XMAX=511, YMIN=YMAX=511, DEGEN=1.
- COORD_W=12, NVERT=4, frame x=(4095,0,2048,7), y=(3,3000,12,99) → XMIN=0, XMAX=4095, YMIN=3, YMAX=3000; OVALID width 12.
